// File: rtl/ara_pkg.sv
// ---------------------------------------------------------------------------
// ara_pkg
// Shared types for the inter-cluster ring slide sequencer.
//   RingCntWidth       : width of the beat-count fields in a slide command
//   ring_slide_cmd_t   : packed slide command {dir, bypass, tx_beats, rx_beats}
//   ring_slide_state_e : sequencer states {IDLE, CONFIG, RUN, DONE}
// ---------------------------------------------------------------------------
package ara_pkg;

  localparam int unsigned RingCntWidth = 16;

  typedef struct packed {
    logic                    dir;       // 0 = slidedown (left), 1 = slideup (right)
    logic                    bypass;    // 1 = this cluster only forwards
    logic [RingCntWidth-1:0] tx_beats;  // beats to send, or to forward when bypass
    logic [RingCntWidth-1:0] rx_beats;  // beats to receive, ignored when bypass
  } ring_slide_cmd_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONFIG = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } ring_slide_state_e;

endpackage

// File: rtl/ring_beat_cnt.sv
// ---------------------------------------------------------------------------
// ring_beat_cnt
// Beat counter with a loadable target. Counts handshakes while enabled and
// refuses to count past the target; a handshake at the target is an overrun.
// Ports:
//   clk_i, rst_i     : clock, synchronous active-high reset
//   load_i           : load tgt_i and clear the count
//   tgt_i            : target beat count
//   en_i             : counting enabled this cycle
//   hs_i             : monitored handshake (valid & ready) this cycle
//   below_o          : count is still below target
//   inc_o            : handshake counted this cycle
//   reached_next_o   : count will equal target after this cycle
//   overrun_o        : handshake arrived while count already at target
// ---------------------------------------------------------------------------
module ring_beat_cnt #(
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                load_i,
  input  logic [CntWidth-1:0] tgt_i,
  input  logic                en_i,
  input  logic                hs_i,
  output logic                below_o,
  output logic                inc_o,
  output logic                reached_next_o,
  output logic                overrun_o
);

  logic [CntWidth-1:0] tgt_q, tgt_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                reached;

  // The count can never pass the target, so equality is the only "done" test.
  assign reached   = (cnt_q == tgt_q);
  assign below_o   = !reached;
  assign inc_o     = en_i && hs_i && !reached;
  assign overrun_o = en_i && hs_i && reached;

  always_comb begin
    tgt_d = tgt_q;
    cnt_d = cnt_q;
    if (load_i) begin
      tgt_d = tgt_i;
      cnt_d = '0;
    end else if (inc_o) begin
      cnt_d = cnt_q + CntWidth'(1);
    end
  end

  // Look-ahead so the sequencer can leave RUN right after the last beat.
  assign reached_next_o = (cnt_d == tgt_d);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tgt_q <= '0;
      cnt_q <= '0;
    end else begin
      tgt_q <= tgt_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ring_slide_ctrl.sv
// ---------------------------------------------------------------------------
// ring_slide_ctrl
// Per-cluster sequencer for one cross-cluster slide over the ring. Accepts a
// slide command, strobes the router configuration, gates and counts tx/rx/fwd
// beats, then pulses done_o. Overruns raise a sticky err_o.
// Optional feature: define RING_SLIDE_CTRL_TIMEOUT_EN to abort a RUN phase that
// sees no counted handshake for TimeoutCycles cycles (err_o set, done_o pulses).
// Ports:
//   clk_i, rst_i                    : clock, synchronous active-high reset
//   cmd_valid_i / cmd_ready_o       : command handshake
//   cmd_dir_i, cmd_bypass_i         : direction, forward-only mode
//   cmd_tx_beats_i, cmd_rx_beats_i  : beat targets
//   tx/rx/fwd_valid_i, _ready_i     : monitored ring handshakes
//   tx_allow_o, rx_allow_o          : gating towards the slide unit
//   dir_o, bypass_o, conf_valid_o   : router configuration
//   busy_o, done_o, err_o           : status
// ---------------------------------------------------------------------------
module ring_slide_ctrl
  import ara_pkg::*;
#(
  parameter int unsigned NrClusters    = 4,
  parameter int unsigned CntWidth      = 16,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic                cmd_dir_i,
  input  logic                cmd_bypass_i,
  input  logic [CntWidth-1:0] cmd_tx_beats_i,
  input  logic [CntWidth-1:0] cmd_rx_beats_i,
  input  logic                tx_valid_i,
  input  logic                tx_ready_i,
  input  logic                rx_valid_i,
  input  logic                rx_ready_i,
  input  logic                fwd_valid_i,
  input  logic                fwd_ready_i,
  output logic                tx_allow_o,
  output logic                rx_allow_o,
  output logic                dir_o,
  output logic                bypass_o,
  output logic                conf_valid_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o
);

  if (NrClusters < 2 || TimeoutCycles < 1) begin : g_bad_params
    $error("ring_slide_ctrl: NrClusters must be >= 2 and TimeoutCycles >= 1");
  end

  ring_slide_state_e state_q, state_d;
  logic dir_q, dir_d, bypass_q, bypass_d, err_q, err_d;
  logic accept, run, complete, timeout;
  logic tx_hs, rx_hs, fwd_hs;
  logic tx_below, rx_below, fwd_below;
  logic tx_inc, rx_inc, fwd_inc;
  logic tx_reach, rx_reach, fwd_reach;
  logic tx_ovr, rx_ovr, fwd_ovr;
  logic stray_hs;

  assign run    = (state_q == RUN);
  assign tx_hs  = tx_valid_i && tx_ready_i;
  assign rx_hs  = rx_valid_i && rx_ready_i;
  assign fwd_hs = fwd_valid_i && fwd_ready_i;

  // tx counter doubles as nothing in bypass: the forward target reuses tx_beats.
  ring_beat_cnt #(.CntWidth(CntWidth)) u_tx_cnt (
    .clk_i, .rst_i, .load_i(accept), .tgt_i(cmd_tx_beats_i),
    .en_i(run && !bypass_q), .hs_i(tx_hs), .below_o(tx_below), .inc_o(tx_inc),
    .reached_next_o(tx_reach), .overrun_o(tx_ovr)
  );
  ring_beat_cnt #(.CntWidth(CntWidth)) u_rx_cnt (
    .clk_i, .rst_i, .load_i(accept), .tgt_i(cmd_rx_beats_i),
    .en_i(run && !bypass_q), .hs_i(rx_hs), .below_o(rx_below), .inc_o(rx_inc),
    .reached_next_o(rx_reach), .overrun_o(rx_ovr)
  );
  ring_beat_cnt #(.CntWidth(CntWidth)) u_fwd_cnt (
    .clk_i, .rst_i, .load_i(accept), .tgt_i(cmd_tx_beats_i),
    .en_i(run && bypass_q), .hs_i(fwd_hs), .below_o(fwd_below), .inc_o(fwd_inc),
    .reached_next_o(fwd_reach), .overrun_o(fwd_ovr)
  );

  // Local tx/rx traffic is illegal while only forwarding.
  assign stray_hs = run && bypass_q && (tx_hs || rx_hs);
  assign complete = bypass_q ? fwd_reach : (tx_reach && rx_reach);

`ifdef RING_SLIDE_CTRL_TIMEOUT_EN
  localparam int unsigned StallW = $clog2(TimeoutCycles + 1);
  logic [StallW-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = '0;
    if (run && !(tx_inc || rx_inc || fwd_inc)) stall_d = stall_q + StallW'(1);
  end
  // Fires on the last stalled cycle so DONE follows TimeoutCycles RUN cycles.
  assign timeout = run && (stall_d == StallW'(TimeoutCycles));

  always_ff @(posedge clk_i) begin
    if (rst_i) stall_q <= '0;
    else       stall_q <= stall_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cmd_ready_o  = 1'b0;
    conf_valid_o = 1'b0;
    done_o       = 1'b0;
    accept       = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready_o = 1'b1;
        if (cmd_valid_i) begin
          accept  = 1'b1;
          state_d = CONFIG;
        end
      end
      CONFIG: begin
        conf_valid_o = 1'b1;
        state_d      = RUN;
      end
      RUN: begin
        if (complete || timeout) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dir_d    = accept ? cmd_dir_i    : dir_q;
    bypass_d = accept ? cmd_bypass_i : bypass_q;
    err_d    = err_q;
    if (accept)                                       err_d = 1'b0;
    else if (tx_ovr || rx_ovr || fwd_ovr || stray_hs) err_d = 1'b1;
    else if (timeout && !complete)                    err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      dir_q    <= 1'b0;
      bypass_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      bypass_q <= bypass_d;
      err_q    <= err_d;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign dir_o      = busy_o && dir_q;
  assign bypass_o   = busy_o && bypass_q;
  assign err_o      = err_q;
  assign tx_allow_o = run && !bypass_q && tx_below;
  assign rx_allow_o = run && !bypass_q && rx_below;

endmodule

// File: tb/tb_ring_slide_ctrl.sv
module tb_ring_slide_ctrl;

`ifdef RING_SLIDE_CTRL_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 1024;
`endif

  logic clk = 1'b0;
  logic rst_i;
  logic cmd_valid_i, cmd_ready_o, cmd_dir_i, cmd_bypass_i;
  logic [15:0] cmd_tx_beats_i, cmd_rx_beats_i;
  logic tx_valid_i, tx_ready_i, rx_valid_i, rx_ready_i, fwd_valid_i, fwd_ready_i;
  logic tx_allow_o, rx_allow_o, dir_o, bypass_o, conf_valid_o, busy_o, done_o, err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ring_slide_ctrl #(.NrClusters(4), .CntWidth(16), .TimeoutCycles(TO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_dir_i(cmd_dir_i), .cmd_bypass_i(cmd_bypass_i),
    .cmd_tx_beats_i(cmd_tx_beats_i), .cmd_rx_beats_i(cmd_rx_beats_i),
    .tx_valid_i(tx_valid_i), .tx_ready_i(tx_ready_i),
    .rx_valid_i(rx_valid_i), .rx_ready_i(rx_ready_i),
    .fwd_valid_i(fwd_valid_i), .fwd_ready_i(fwd_ready_i),
    .tx_allow_o(tx_allow_o), .rx_allow_o(rx_allow_o),
    .dir_o(dir_o), .bypass_o(bypass_o), .conf_valid_o(conf_valid_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic quiet_hs();
    tx_valid_i = 0; tx_ready_i = 0; rx_valid_i = 0; rx_ready_i = 0;
    fwd_valid_i = 0; fwd_ready_i = 0;
  endtask

  // Idle outputs: only cmd_ready_o is high, err_o as expected.
  task automatic chk_idle(input string tag, input logic exp_err);
    chk({tag, "_ready"}, cmd_ready_o, 1);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_outs"}, {tx_allow_o, rx_allow_o, dir_o, bypass_o, conf_valid_o, done_o}, 0);
    chk({tag, "_err"}, err_o, exp_err);
  endtask

  // Accept a command in the current IDLE cycle and check the CONFIG cycle.
  task automatic accept_cmd(input logic dir, input logic byp, input int tx, input int rx,
                            input bit hold);
    @(negedge clk);
    chk("acc_ready", cmd_ready_o, 1);
    chk("acc_busy", busy_o, 0);
    cmd_valid_i = 1; cmd_dir_i = dir; cmd_bypass_i = byp;
    cmd_tx_beats_i = 16'(tx); cmd_rx_beats_i = 16'(rx);
    @(negedge clk);
    if (!hold) cmd_valid_i = 0;
    chk("cfg_conf", conf_valid_o, 1);
    chk("cfg_dir", dir_o, dir);
    chk("cfg_byp", bypass_o, byp);
    chk("cfg_ready", cmd_ready_o, 0);
    chk("cfg_err", err_o, 0);
    chk("cfg_allow", {tx_allow_o, rx_allow_o}, 0);
  endtask

  // Full command against a beat-count model: random valid/ready, handshakes
  // offered only when the model still needs beats, optional overrun injection.
  task automatic run_cmd(input logic dir, input logic byp, input int tx, input int rx,
                         input bit inject, input bit hold);
    int txn = 0, rxn = 0, fwn = 0, runcyc = 0;
    bit fin = 0, injected = 0;
    logic exp_err = 0;
    accept_cmd(dir, byp, tx, rx, hold);
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(negedge clk);
      runcyc++;
      chk("run_done", done_o, 0);
      chk("run_conf", conf_valid_o, 0);
      chk("run_busy", busy_o, 1);
      chk("run_ready", cmd_ready_o, 0);
      chk("run_dir", {dir_o, bypass_o}, {dir, byp});
      chk("run_txallow", tx_allow_o, !byp && txn < tx);
      chk("run_rxallow", rx_allow_o, !byp && rxn < rx);
      chk("run_err", err_o, exp_err);
      tx_valid_i  = 1'($urandom_range(0, 1));
      rx_valid_i  = 1'($urandom_range(0, 1));
      fwd_valid_i = 1'($urandom_range(0, 1));
      tx_ready_i  = (!byp && txn < tx) ? 1'($urandom_range(0, 1)) : 1'b0;
      rx_ready_i  = (!byp && rxn < rx && !(inject && !injected)) ? 1'($urandom_range(0, 1)) : 1'b0;
      fwd_ready_i = (byp && fwn < tx) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (inject && !injected && txn == tx) begin
        tx_valid_i = 1; tx_ready_i = 1; injected = 1;
      end
      // Beat-count rules: a handshake counts while below target, else it is an error.
      if (tx_valid_i && tx_ready_i) begin
        if (byp || txn == tx) exp_err = 1; else txn++;
      end
      if (rx_valid_i && rx_ready_i) begin
        if (byp || rxn == rx) exp_err = 1; else rxn++;
      end
      if (byp && fwd_valid_i && fwd_ready_i) begin
        if (fwn == tx) exp_err = 1; else fwn++;
      end
      fin = byp ? (fwn == tx) : (txn == tx && rxn == rx && (!inject || injected));
    end
    @(negedge clk);
    quiet_hs();
    if (!fin) begin
      chk("run_budget", 0, 1);
    end else begin
      chk("done_pulse", done_o, 1);
      chk("done_err", err_o, exp_err);
      chk("done_ready", cmd_ready_o, 0);
      chk("done_dir", {dir_o, bypass_o}, {dir, byp});
      if (tx == 0 && rx == 0) chk("zero_run_len", runcyc, 1);
    end
    $display("cmd dir=%0d byp=%0d tx=%0d rx=%0d inj=%0d run_cycles=%0d err=%0d",
             dir, byp, tx, rx, inject, runcyc, err_o);
  endtask

  initial begin
    rst_i = 1; cmd_valid_i = 0; cmd_dir_i = 0; cmd_bypass_i = 0;
    cmd_tx_beats_i = 0; cmd_rx_beats_i = 0; quiet_hs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 0;
    chk_idle("reset", 0);

    // Normal slideup, 4/4 beats.
    run_cmd(1, 0, 4, 4, 0, 0);
    // Zero-count command: done 3 cycles after accept, allows never high.
    run_cmd(0, 0, 0, 0, 0, 0);
    // Forward-only with cmd_valid held high during the whole command.
    run_cmd(0, 1, 3, 0, 0, 1);
    // Next command is accepted only back in IDLE; the held request is it.
    // Overrun on tx, then the next accepted command clears err_o.
    run_cmd(1, 0, 2, 1, 1, 0);
    @(negedge clk);
    chk_idle("post_ovr_idle", 1);
    run_cmd(0, 0, 1, 2, 0, 0);

    // Randomized commands.
    for (int i = 0; i < 6; i++)
      run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), 0, 0);

    // Reset in RUN after one of four tx beats: silent abort.
    accept_cmd(0, 0, 4, 4, 0);
    @(negedge clk);
    tx_valid_i = 1; tx_ready_i = 1;
    @(negedge clk);
    quiet_hs();
    rst_i = 1;
    @(negedge clk);
    rst_i = 0;
    chk_idle("rst_abort", 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_no_done", done_o, 0);
    end
    $display("reset abort checked");

    // Stalled command: rx=2 with no rx handshakes.
    accept_cmd(1, 0, 0, 2, 0);
`ifdef RING_SLIDE_CTRL_TIMEOUT_EN
    for (int i = 0; i <= TO; i++) begin
      @(negedge clk);
      chk("to_done", done_o, i == TO);
      chk("to_err", err_o, i == TO);
    end
    $display("timeout after %0d run cycles checked", TO);
`else
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      chk("stall_busy", busy_o, 1);
      chk("stall_done", done_o, 0);
    end
    $display("stall still busy after 100 cycles");
    rst_i = 1;
    @(negedge clk);
    rst_i = 0;
`endif
    @(negedge clk);
    chk("final_idle", busy_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
